// File: rtl/led_display_scanner.sv
// led_display_scanner: time-multiplexes a staged 4-digit hex value
// onto one shared 7-segment decoder with per-slot anode blanking.
module led_display_scanner #(
   parameter int REFRESH_CNT = 16,
   parameter int BLANK_CNT   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic        load,
   output logic [3:0]  char_out,
   output logic [3:0]  an,
   output logic        frame_start
);

   localparam int CW = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
   localparam logic [CW-1:0] LAST = CW'(REFRESH_CNT - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    digit;
   logic [15:0]   disp;
   logic [15:0]   pend;
   logic          pend_v;
   logic          slot_end;
   logic          frame_end;
   logic          blank;

   assign slot_end  = (cnt == LAST);
   assign frame_end = slot_end && (digit == 2'd0);

   // Blanking window at the start of each slot; absent when BLANK_CNT is 0
   generate
      if (BLANK_CNT == 0) begin : g_noblank
         assign blank = 1'b0;
      end else begin : g_blank
         assign blank = (cnt < CW'(BLANK_CNT));
      end
   endgenerate

   assign an          = blank ? 4'b1111 : ~(4'b0001 << digit);
   assign char_out    = disp[4*digit +: 4];
   assign frame_start = (cnt == '0) && (digit == 2'd3);

   // Slot counter, digit scan and frame-aligned commit of staged data
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         digit  <= 2'd3;
         disp   <= '0;
         pend   <= '0;
         pend_v <= 1'b0;
      end else begin
         if (slot_end) begin
            cnt   <= '0;
            digit <= digit - 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
         if (load) begin
            pend <= data_in;
         end
         if (frame_end) begin
            pend_v <= 1'b0;
            if (load) begin
               disp <= data_in;
            end else if (pend_v) begin
               disp <= pend;
            end
         end else if (load) begin
            pend_v <= 1'b1;
         end
      end
   end

endmodule
